// File: rtl/gate_io_pkg.sv
// Shared types for the three-input gate conditioning path.
package gate_io_pkg;

    // Conditioned vector feeding the gate, bit order {in1,in2,in3}, in1 = MSB.
    typedef logic [2:0] gate_vec_t;

    // Debounce tracker state.
    typedef enum logic [1:0] {
        INIT,
        STABLE,
        CONFIRM
    } db_state_t;

    // Depth of the input synchroniser.
    localparam int SYNC_STAGES = 2;

endpackage : gate_io_pkg

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old values, forming a real two-stage pipeline.
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync2

// File: rtl/input_debounce3.sv
// Debounces three raw inputs into glitch-free levels for a 3-input gate.
// Each input is synchronised, then a new 3-bit vector is accepted only after
// it has been sampled STABLE_CYCLES consecutive times.
// Optional feature: define CHANGE_CNT_EN to add the saturating change_cnt port.
// rst_n is assumed to be released synchronously to clk by the reset tree.
module input_debounce3
    import gate_io_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CHG_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in1_raw,
    input  logic             in2_raw,
    input  logic             in3_raw,
    input  logic             sample_en,
    output logic             in1,
    output logic             in2,
    output logic             in3,
    output logic             valid,
    output logic             changed
`ifdef CHANGE_CNT_EN
    ,
    output logic [CHG_W-1:0] change_cnt
`endif
);

    localparam int CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam int PRIME_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $error("input_debounce3: STABLE_CYCLES must be >= 1");
    end
    if (CHG_W < 1) begin : g_bad_chg_w
        $error("input_debounce3: CHG_W must be >= 1");
    end

    gate_vec_t           s;
    gate_vec_t           cand;
    gate_vec_t           cand_nxt;
    gate_vec_t           out_vec;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [PRIME_W-1:0]  prime_cnt;
    logic                primed;
    logic                take;
    logic                hit;
    logic                accept_change;
    db_state_t           state;

    sync2 #(
        .W ($bits(gate_vec_t))
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({in1_raw, in2_raw, in3_raw}),
        .q     (s)
    );

    // The synchroniser holds reset zeros for its first edges; samples are only
    // trusted once it has been filled with real input data.
    assign primed = (prime_cnt == PRIME_MAX);

    // Next candidate/count and the accept decision for this edge.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        take     = sample_en && primed;
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (take) begin
            if (s != cand) begin
                cand_nxt = s;
                cnt_nxt  = CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        // Accept only on the edge the count reaches the target, not while it sits saturated.
        hit           = take && (cnt_nxt == CNT_MAX) && ((cnt != CNT_MAX) || (s != cand));
        accept_change = hit && ((state == INIT) || (cand_nxt != out_vec));
    end

    // Candidate vector, stability count and synchroniser fill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: only control/datapath registers are reset here; there is no memory array to clear.
        if (!rst_n) begin
            cand      <= '0;
            cnt       <= '0;
            prime_cnt <= '0;
        end else begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
            if (!primed) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    // Debounce FSM with registered gate outputs and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            out_vec <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (hit) begin
                state <= STABLE;
                if (accept_change) begin
                    out_vec <= cand_nxt;
                    changed <= 1'b1;
                    valid   <= 1'b1;
                end
            end else if (take) begin
                unique case (state)
                    STABLE:  if (cand_nxt != out_vec) state <= CONFIRM;
                    CONFIRM: if (s == out_vec)        state <= STABLE;
                    default: ;
                endcase
            end
        end
    end

    assign {in1, in2, in3} = out_vec;

`ifdef CHANGE_CNT_EN
    // Saturating count of accepted output changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_cnt <= '0;
        end else if (accept_change && (change_cnt != {CHG_W{1'b1}})) begin
            change_cnt <= change_cnt + 1'b1;
        end
    end
`endif

endmodule : input_debounce3

// File: tb/tb_input_debounce3.sv
// Self-checking bench for input_debounce3: directed scenarios plus randomized
// stimulus, all compared against a run-length reference model.
module tb_input_debounce3;

    localparam int SC = 4;
`ifdef CHANGE_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic clk;
    logic rst_n;
    logic in1_raw, in2_raw, in3_raw;
    logic sample_en;
    logic in1, in2, in3;
    logic valid, changed;
`ifdef CHANGE_CNT_EN
    logic [CW-1:0] change_cnt;
`endif

    input_debounce3 #(
        .STABLE_CYCLES (SC),
        .CHG_W         (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in1_raw    (in1_raw),
        .in2_raw    (in2_raw),
        .in3_raw    (in3_raw),
        .sample_en  (sample_en),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .valid      (valid),
        .changed    (changed)
`ifdef CHANGE_CNT_EN
        ,
        .change_cnt (change_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw history per edge, trailing run of identical samples.
    logic [2:0] hist[$];
    logic [2:0] m_run_val;
    int         m_run_len;
    logic [2:0] m_out;
    logic       m_valid;
    logic       m_changed;
    int         m_cc;
    int         edge_n;

    task automatic model_clear();
        hist.delete();
        m_run_val = 3'b000;
        m_run_len = 0;
        m_out     = 3'b000;
        m_valid   = 1'b0;
        m_changed = 1'b0;
        m_cc      = 0;
        edge_n    = 0;
    endtask

    // Drive one cycle of stimulus, take the edge, advance the model, settle.
    task automatic step(input logic [2:0] raw, input logic en);
        logic [2:0] s;
        {in1_raw, in2_raw, in3_raw} = raw;
        sample_en = en;
        @(posedge clk);
        hist.push_back(raw);
        edge_n++;
        m_changed = 1'b0;
        // The value seen by the debouncer is the raw input from two edges ago.
        if (en && hist.size() >= 3) begin
            s = hist[hist.size() - 3];
            if (m_run_len > 0 && s == m_run_val) begin
                m_run_len++;
            end else begin
                m_run_val = s;
                m_run_len = 1;
            end
            if (m_run_len == SC && (!m_valid || m_run_val != m_out)) begin
                m_out     = m_run_val;
                m_valid   = 1'b1;
                m_changed = 1'b1;
                if (m_cc < (1 << CW) - 1) m_cc++;
            end
        end
        if (hist.size() > 3) void'(hist.pop_front());
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        int pulse_edge = -1;
        {in1_raw, in2_raw, in3_raw} = 3'b000;
        sample_en = 1'b1;
        assert_reset();
        n_checks++;
        if ({in1, in2, in3, valid, changed} !== 5'b0)
            $display("FAIL reset_state: got out=%b%b%b valid=%b changed=%b, want all 0",
                     in1, in2, in3, valid, changed);
        else n_pass++;
        release_reset();
        for (int i = 1; i <= 9; i++) begin
            step(3'b000, 1'b1);
            if (changed === 1'b1) begin
                pulses++;
                pulse_edge = i;
            end
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL reset_accept edge %0d: got %b%b%b v=%b c=%b, want %b v=%b c=%b",
                         i, in1, in2, in3, valid, changed, m_out, m_valid, m_changed);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 1 || pulse_edge !== 6 || valid !== 1'b1)
            $display("FAIL reset_first_accept: got pulses=%0d at edge %0d valid=%b, want 1 at edge 6 valid=1",
                     pulses, pulse_edge, valid);
        else n_pass++;
    endtask

    task automatic test_step_101();
        int pulses = 0;
        int pulse_edge = -1;
        for (int i = 1; i <= 10; i++) begin
            step(3'b101, 1'b1);
            if (changed === 1'b1) begin
                pulses++;
                pulse_edge = i;
            end
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL step_101 edge %0d: got %b%b%b v=%b c=%b, want %b v=%b c=%b",
                         i, in1, in2, in3, valid, changed, m_out, m_valid, m_changed);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 1 || pulse_edge !== 6 || {in1, in2, in3} !== 3'b101)
            $display("FAIL step_101_latency: got pulses=%0d at edge %0d out=%b%b%b, want 1 at edge 6 out=101",
                     pulses, pulse_edge, in1, in2, in3);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        logic [2:0] raw;
        // Settle back to 000 first, then glitch to 110 for three cycles.
        for (int i = 0; i < 8; i++) begin
            step(3'b000, 1'b1);
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL glitch_settle step %0d: got %b%b%b c=%b, want %b c=%b",
                         i, in1, in2, in3, changed, m_out, m_changed);
            else n_pass++;
        end
        for (int i = 0; i < 14; i++) begin
            raw = (i < 3) ? 3'b110 : 3'b000;
            step(raw, 1'b1);
            if (changed === 1'b1) pulses++;
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL glitch step %0d: got %b%b%b c=%b, want %b c=%b",
                         i, in1, in2, in3, changed, m_out, m_changed);
            else n_pass++;
        end
        n_checks++;
        if (pulses !== 0 || {in1, in2, in3} !== 3'b000)
            $display("FAIL glitch_rejected: got pulses=%0d out=%b%b%b, want 0 pulses out=000",
                     pulses, in1, in2, in3);
        else n_pass++;
    endtask

    task automatic test_sample_en_freeze();
        int en_edges = 0;
        int pulse_at = -1;
        for (int i = 0; i < 2; i++) begin
            step(3'b010, 1'b1);
            n_checks++;
            if ({in1, in2, in3, changed} !== {m_out, m_changed})
                $display("FAIL freeze_pre %0d: got %b%b%b c=%b, want %b c=%b",
                         i, in1, in2, in3, changed, m_out, m_changed);
            else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            step(3'b010, 1'b0);
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL freeze_hold %0d: got %b%b%b c=%b, want %b c=%b",
                         i, in1, in2, in3, changed, m_out, m_changed);
            else n_pass++;
        end
        for (int i = 1; i <= 6; i++) begin
            step(3'b010, 1'b1);
            en_edges++;
            if (changed === 1'b1 && pulse_at < 0) pulse_at = en_edges;
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL freeze_resume %0d: got %b%b%b c=%b, want %b c=%b",
                         i, in1, in2, in3, changed, m_out, m_changed);
            else n_pass++;
        end
        n_checks++;
        if (pulse_at !== SC || {in1, in2, in3} !== 3'b010)
            $display("FAIL freeze_latency: got update at sample %0d out=%b%b%b, want sample %0d out=010",
                     pulse_at, in1, in2, in3, SC);
        else n_pass++;
    endtask

    task automatic test_reset_mid_confirm();
        for (int i = 0; i < 4; i++) step(3'b111, 1'b1);
        assert_reset();
        n_checks++;
        if ({in1, in2, in3, valid, changed} !== 5'b0)
            $display("FAIL reset_mid_confirm: got out=%b%b%b valid=%b changed=%b, want all 0",
                     in1, in2, in3, valid, changed);
        else n_pass++;
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            step(3'b111, 1'b1);
            n_checks++;
            if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                $display("FAIL reset_reaccept edge %0d: got %b%b%b v=%b c=%b, want %b v=%b c=%b",
                         i, in1, in2, in3, valid, changed, m_out, m_valid, m_changed);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0] raw;
        logic       en;
        int         hold;
        for (int burst = 0; burst < 120; burst++) begin
            raw  = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 7);
            for (int j = 0; j < hold; j++) begin
                en = ($urandom_range(0, 9) != 0);
                step(raw, en);
                n_checks++;
                if ({in1, in2, in3, valid, changed} !== {m_out, m_valid, m_changed})
                    $display("FAIL random edge %0d: got %b%b%b v=%b c=%b, want %b v=%b c=%b",
                             edge_n, in1, in2, in3, valid, changed, m_out, m_valid, m_changed);
                else n_pass++;
            end
        end
    endtask

    task automatic test_change_cnt();
`ifdef CHANGE_CNT_EN
        logic [2:0] seq[5];
        seq = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        assert_reset();
        release_reset();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) begin
                step(seq[k], 1'b1);
                n_checks++;
                if (change_cnt !== CW'(m_cc))
                    $display("FAIL change_cnt vec %0d step %0d: got %0d, want %0d",
                             k, j, change_cnt, m_cc);
                else n_pass++;
            end
        end
        n_checks++;
        if (change_cnt !== CW'(3))
            $display("FAIL change_cnt_saturate: got %0d, want 3", change_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        rst_n     = 1'b1;
        sample_en = 1'b0;
        {in1_raw, in2_raw, in3_raw} = 3'b000;
        model_clear();
        test_reset();
        test_step_101();
        test_glitch();
        test_sample_en_freeze();
        test_reset_mid_confirm();
        test_random();
        test_change_cnt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_input_debounce3
